// File: rtl/serial_add_arbiter.sv
// Serial adder shared by two requesters.
// A single 1-bit full adder plus a carry flop processes one operand bit per
// cycle. A round-robin arbiter picks which requester's operands are loaded,
// and the result is held until the consumer accepts it.
`timescale 1ns/1ps
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    input  logic             res_ready
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             last;     // requester served most recently
    logic             pick1;    // requester 1 wins this arbitration
    logic             any_req;
    logic             last_bit;
    logic             fa_sum, fa_cy;

    // Arbitration: on a tie, the requester not served last wins.
    always_comb begin
        any_req  = req0 | req1;
        pick1    = req1 & (~req0 | ~last);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // The one shared full adder, fed by the operand LSBs and the carry flop.
    always_comb begin
        fa_sum = opa[0] ^ opb[0] ^ cy;
        fa_cy  = (opa[0] & opb[0]) | (opa[0] & cy) | (opb[0] & cy);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: no grant can happen on the DONE->IDLE edge because the
    // grant is only taken while already in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture on the grant edge, then one bit per SHIFT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa      <= '0;
            opb      <= '0;
            cy       <= 1'b0;
            cnt      <= '0;
            last     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_id   <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        opa      <= pick1 ? a1 : a0;
                        opb      <= pick1 ? b1 : b0;
                        cy       <= pick1 ? cin1 : cin0;
                        res_id   <= pick1;
                        last     <= pick1;
                        gnt0     <= ~pick1;
                        gnt1     <= pick1;
                        cnt      <= '0;
                        res_sum  <= '0;
                        res_cout <= 1'b0;
                    end
                end
                SHIFT: begin
                    opa     <= opa >> 1;
                    opb     <= opb >> 1;
                    cy      <= fa_cy;
                    res_sum <= {fa_sum, res_sum[WIDTH-1:1]};
                    cnt     <= cnt + CW'(1);
                    if (last_bit) res_cout <= fa_cy;
                end
                default: ;
            endcase
        end
    end

    // Status outputs follow the state directly.
    always_comb begin
        busy      = (state != IDLE);
        res_valid = (state == DONE);
    end

endmodule

// File: doc/serial_add_arbiter.md
SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req0/req1, input, 1 each, requester add request, held high until the matching grant.
REQ-005 The block SHALL have ports a0/b0/a1/b1, input, WIDTH each, requester operands, sampled only on the grant edge.
REQ-006 The block SHALL have ports cin0/cin1, input, 1 each, requester carry-in, sampled only on the grant edge.
REQ-007 The block SHALL have ports gnt0/gnt1, output, 1 each, one-cycle pulse marking operand capture.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 The block SHALL have ports res_valid (1), res_sum (WIDTH), res_cout (1) and res_id (1, 0=requester0, 1=requester1), all outputs.
REQ-010 The block SHALL have port res_ready, input, 1, result consumer accept.

Function
REQ-011 The block SHALL contain exactly one 1-bit full adder (sum = x^y^c, carry = majority) plus a carry flip-flop, shared by both requesters.
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 In IDLE with any req high, the next edge SHALL: capture the winner's operands and carry-in, set res_id, pulse that gnt for one cycle, clear the bit counter and enter SHIFT.
REQ-014 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; after reset, requester 0 wins first.
REQ-015 In SHIFT, each edge SHALL add the LSBs of the operand shift registers with the carry flop, shift the sum bit into res_sum from the MSB side, update the carry flop and increment the counter.
REQ-016 After exactly WIDTH SHIFT edges, the FSM SHALL enter DONE; res_valid SHALL rise WIDTH cycles after the grant edge.
REQ-017 In DONE, res_valid SHALL be high and res_sum/res_cout/res_id SHALL be stable until a cycle with res_ready high.
REQ-018 A DONE cycle with res_ready high SHALL complete the transfer: next edge goes to IDLE and drops res_valid; no grant is issued in the same edge.
REQ-019 res_sum SHALL equal (a+b+cin) mod 2^WIDTH; res_cout SHALL equal the carry out of bit WIDTH-1.
REQ-020 Requests during SHIFT or DONE SHALL be ignored (no grant) and SHALL be served in IDLE per REQ-014.
REQ-021 res_ready while not in DONE SHALL have no effect.
REQ-022 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-023 rst_n low SHALL immediately force IDLE and clear gnt0, gnt1, busy, res_valid, res_sum, res_cout, res_id, carry flop, counter and operand registers to 0; the last-served pointer SHALL be set to requester 1.
REQ-024 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no result delivered; after release, the first request is arbitrated per REQ-014.

Verification (WIDTH=8)
REQ-025 req0, a0=8'hFF, b0=8'h01, cin0=0, res_ready=1 -> gnt0 one cycle, res_valid 8 cycles later, res_sum=8'h00, res_cout=1, res_id=0.
REQ-026 req1, a1=8'h7F, b1=8'h80, cin1=1 -> res_sum=8'h00, res_cout=1, res_id=1; then a1=8'h12, b1=8'h34, cin1=0 -> res_sum=8'h46, res_cout=0.
REQ-027 req0 and req1 high from reset release -> gnt0 first (res_id=0), then gnt1 in the first IDLE cycle after the transfer (res_id=1); gnt never simultaneous.
REQ-028 Operation complete, res_ready held low 5 cycles -> res_valid and res_sum stable for all 5 cycles; res_ready high -> IDLE next edge, res_valid low.
REQ-029 rst_n pulsed low after 3 SHIFT edges -> all outputs 0 immediately, no res_valid; a new req0 then completes correctly.
REQ-030 req0 toggled after grant, operands changed during SHIFT -> result reflects grant-edge operands only.
